// File: rtl/ctrl_mux_7_seg.sv
// ctrl_mux_7_seg
// Scan controller for N_DIG common-anode 7-segment digits that share one
// hex decoder. It holds a double-buffered display word, presents one nibble
// per slot to the decoder, registers the decoder result and enables one
// digit at a time. Each slot opens with a dead-time, and leading zeros can
// optionally be blanked.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous reset, active high
//   dados        display word, digit i = dados[4i+3:4i] (digit 0 = LSD)
//   carga        one-cycle load strobe for dados
//   apaga_zeros  leading-zero blanking enable, sampled at slot start
//   dig_valor    nibble presented to the shared decoder
//   dec_saida    decoder result (a..g, MSB = a, 1 = lit)
//   segmentos    registered segment drive (1 = lit)
//   anodo        digit enables, active low, at most one bit low
//   quadro       high on the first cycle of every frame
//
// state | meaning
// ------+----------------------------------------------------------
// BLANK | dead-time at the start of a slot, all anodes off
// ON    | current digit enabled (unless blanked as a leading zero)
module ctrl_mux_7_seg #(
    parameter int N_DIG = 4,
    parameter int DIV   = 50000,
    parameter int DEAD  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*N_DIG-1:0] dados,
    input  logic               carga,
    input  logic               apaga_zeros,
    output logic [3:0]         dig_valor,
    input  logic [6:0]         dec_saida,
    output logic [6:0]         segmentos,
    output logic [N_DIG-1:0]   anodo,
    output logic               quadro
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(N_DIG);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(N_DIG - 1);

    typedef enum logic {BLANK, ON} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [4*N_DIG-1:0]   r_pendente;
    logic                 r_pend;
    logic [4*N_DIG-1:0]   r_ativo;
    logic                 r_blank;
    logic [3:0]           r_dig_valor;
    logic [6:0]           r_segmentos;
    logic [N_DIG-1:0]     r_anodo;
    logic [N_DIG-1:0]     w_anodo_nxt;

    logic                 w_slot_end;
    logic                 w_frame_end;
    logic [IW-1:0]        w_idx_nxt;
    logic [4*N_DIG-1:0]   w_ativo_nxt;
    logic                 w_upper_zero;
    logic                 w_blank_nxt;
    logic [N_DIG-1:0]     w_digit_on;

    assign w_slot_end  = (r_cnt == CNT_MAX);
    assign w_frame_end = w_slot_end && (r_idx == IDX_MAX);
    assign w_idx_nxt   = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    assign w_digit_on  = ~(N_DIG'(1) << r_idx);

    // A load arriving on the boundary cycle bypasses the pending buffer so
    // it is shown in the very next frame.
    always_comb begin
        w_ativo_nxt = r_ativo;
        if (w_frame_end) begin
            if (carga)
                w_ativo_nxt = dados;
            else if (r_pend)
                w_ativo_nxt = r_pendente;
        end
    end

    // Blank the upcoming digit when it and every more significant digit
    // of the word being shown are zero; digit 0 is always shown.
    always_comb begin
        w_upper_zero = 1'b1;
        for (int i = 0; i < N_DIG; i++) begin
            if ((IW'(i) >= w_idx_nxt) && (w_ativo_nxt[4*i +: 4] != 4'd0))
                w_upper_zero = 1'b0;
        end
        w_blank_nxt = apaga_zeros && (w_idx_nxt != '0) && w_upper_zero;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_pendente  <= '0;
            r_pend      <= 1'b0;
            r_ativo     <= '0;
            r_blank     <= 1'b0;
            r_dig_valor <= '0;
            r_segmentos <= '0;
        end else begin
            r_cnt       <= w_slot_end ? '0 : r_cnt + 1'b1;
            r_ativo     <= w_ativo_nxt;
            r_segmentos <= dec_saida;
            if (w_slot_end) begin
                r_idx       <= w_idx_nxt;
                r_dig_valor <= w_ativo_nxt[{w_idx_nxt, 2'b00} +: 4];
                r_blank     <= w_blank_nxt;
            end
            if (w_frame_end) begin
                r_pend <= 1'b0;
            end else if (carga) begin
                r_pendente <= dados;
                r_pend     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BLANK;
            r_anodo <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_anodo <= w_anodo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_anodo_nxt = r_anodo;
        if (w_slot_end) begin
            w_state_nxt = BLANK;
            w_anodo_nxt = '1;
        end else begin
            case (r_state)
                BLANK: begin
                    if (r_cnt == CNT_DEAD) begin
                        w_state_nxt = ON;
                        w_anodo_nxt = r_blank ? '1 : w_digit_on;
                    end
                end
                ON: ;
                default: w_state_nxt = BLANK;
            endcase
        end
    end

    assign dig_valor = r_dig_valor;
    assign segmentos = r_segmentos;
    assign anodo     = r_anodo;
    // Gated by rst so the pulse appears on the first cycle after release
    // but not while reset is held.
    assign quadro    = ~rst && (r_cnt == '0) && (r_idx == '0);

endmodule
